// File: rtl/xor_setup_hold_sequencer_if.sv
// ---------------------------------------------------------------------------
// xor_setup_hold_sequencer_if
// Operand/result handshake bundle for xor_setup_hold_sequencer.
//   in_valid/in_ready   : operand pair handshake (producer -> sequencer)
//   in_a/in_b           : operand pair, WIDTH bits each
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_data            : captured XOR result, WIDTH bits
// modport master : the side that supplies operands and consumes results
// modport slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface xor_setup_hold_sequencer_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xor_setup_hold_sequencer.sv
// ---------------------------------------------------------------------------
// xor_setup_hold_sequencer
// Feeds operand pairs into a clocked XOR cell so that its setup and hold
// windows are met by construction: the operands are launched, held for
// SETUP_CYC cycles, the cell clock is pulsed for one cycle, the operands are
// held HOLD_CYC more cycles, then the cell output is captured, checked
// against the expected XOR and returned on the result handshake.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active high
//   bus       : operand/result handshake (slave modport)
//   xor_a/b   : drive the XOR cell inputs (registered)
//   xor_clk   : drives the XOR cell clock, one-cycle high pulse per op
//   xor_out   : XOR cell registered output
//   busy      : high whenever the sequencer is not idle
//   mismatch  : sticky flag, captured result differed from expected XOR
//   op_count  : completed result handshakes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module xor_setup_hold_sequencer #(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  xor_setup_hold_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]           xor_a,
  output logic [WIDTH-1:0]           xor_b,
  output logic                       xor_clk,
  input  logic [WIDTH-1:0]           xor_out,
  output logic                       busy,
  output logic                       mismatch,
  output logic [CNT_W-1:0]           op_count
);

  // Both windows need at least one full cycle to be meaningful.
  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("xor_setup_hold_sequencer: SETUP_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("xor_setup_hold_sequencer: HOLD_CYC must be >= 1");
  end

  localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]    HOLD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    CNT_ZERO   = CW'(32'd0);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(32'd1);
  localparam logic [CNT_W-1:0] OPS_ONE    = CNT_W'(32'd1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_xor_a;
  logic [WIDTH-1:0] r_xor_b;
  logic             r_xor_clk;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_op_count;
  logic             w_idle;

  // Sequencer FSM plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_exp       <= {WIDTH{1'b0}};
      r_xor_a     <= {WIDTH{1'b0}};
      r_xor_b     <= {WIDTH{1'b0}};
      r_xor_clk   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
      r_mismatch  <= 1'b0;
      r_op_count  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Operands are only ever sampled here, so xor_a/xor_b stay
          // frozen for the whole operation.
          if (bus.in_valid) begin
            r_xor_a <= bus.in_a;
            r_xor_b <= bus.in_b;
            r_exp   <= bus.in_a ^ bus.in_b;
            r_cnt   <= SETUP_LOAD;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // The clock pulse is registered, so it is raised on the edge
          // that enters STROBE and is high for exactly the STROBE cycle.
          if (r_cnt == CNT_ZERO) begin
            r_xor_clk <= 1'b1;
            r_state   <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_STROBE: begin
          r_xor_clk <= 1'b0;
          r_cnt     <= HOLD_LOAD;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == CNT_ZERO) begin
            r_out_data  <= xor_out;
            r_mismatch  <= r_mismatch | (xor_out != r_exp);
            r_out_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + OPS_ONE;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_xor_clk   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_idle        = (r_state == ST_IDLE);
  assign bus.in_ready  = w_idle;
  assign busy          = ~w_idle;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign xor_a         = r_xor_a;
  assign xor_b         = r_xor_b;
  assign xor_clk       = r_xor_clk;
  assign mismatch      = r_mismatch;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_xor_setup_hold_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xor_setup_hold_sequencer
// Directed bench for xor_setup_hold_sequencer. A cycle-count model (age of the
// current operation since its accept edge) predicts every output and is
// compared on each falling edge; directed sequences add literal expectations.
// A second instance with CNT_W=2 shares the stimulus to exercise wrap.
// ---------------------------------------------------------------------------
module tb_xor_setup_hold_sequencer;
  localparam int W     = 1;
  localparam int SCYC  = 2;
  localparam int HCYC  = 1;
  localparam int LAT   = SCYC + 1 + HCYC;

  logic clk;
  logic rst;
  logic stuck;

  xor_setup_hold_sequencer_if #(.WIDTH(W)) bus ();
  xor_setup_hold_sequencer_if #(.WIDTH(W)) bus2 ();

  logic [W-1:0] xa, xb, xa2, xb2;
  logic [W-1:0] xo  = '0;
  logic [W-1:0] xo2 = '0;
  logic         xclk, xclk2, busy, busy2, mis, mis2;
  logic [7:0]   opc;
  logic [1:0]   opc2;

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_a      = bus.in_a;
  assign bus2.in_b      = bus.in_b;
  assign bus2.out_ready = bus.out_ready;

  xor_setup_hold_sequencer #(.WIDTH(W), .SETUP_CYC(SCYC), .HOLD_CYC(HCYC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .xor_a(xa), .xor_b(xb), .xor_clk(xclk),
    .xor_out(xo), .busy(busy), .mismatch(mis), .op_count(opc));

  xor_setup_hold_sequencer #(.WIDTH(W), .SETUP_CYC(SCYC), .HOLD_CYC(HCYC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .xor_a(xa2), .xor_b(xb2), .xor_clk(xclk2),
    .xor_out(xo2), .busy(busy2), .mismatch(mis2), .op_count(opc2));

  // Behavioural basic_xor cells; the first can be forced to output 0.
  always @(posedge xclk)  xo  <= stuck ? '0 : (xa ^ xb);
  always @(posedge xclk2) xo2 <= xa2 ^ xb2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- model: age of the operation since its accept edge
  bit           m_on = 1'b0;
  bit           m_busy, m_valid, m_mis;
  int           m_age, m_cnt;
  logic [W-1:0] m_xa, m_xb, m_res, m_data, m_data2;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
      m_age = 0; m_cnt = 0; m_xa = '0; m_xb = '0; m_res = '0;
      m_data = '0; m_data2 = '0;
    end else if (m_busy) begin
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 1'b0; m_busy = 1'b0; m_cnt++;
        end
      end else begin
        m_age++;
        if (m_age == LAT) begin
          m_valid = 1'b1;
          m_data  = m_res;
          m_data2 = m_xa ^ m_xb;
          if (m_res != (m_xa ^ m_xb)) m_mis = 1'b1;
        end
      end
    end else if (bus.in_valid) begin
      m_busy = 1'b1; m_age = 0;
      m_xa = bus.in_a; m_xb = bus.in_b;
      m_res = stuck ? '0 : (bus.in_a ^ bus.in_b);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready",  bus.in_ready,  !m_busy);
      chk("busy",      busy,          m_busy);
      chk("out_valid", bus.out_valid, m_valid);
      chk("xor_clk",   xclk,          m_busy && !m_valid && (m_age == SCYC));
      chk("xor_a",     xa,            m_xa);
      chk("xor_b",     xb,            m_xb);
      chk("out_data",  bus.out_data,  m_data);
      chk("mismatch",  mis,           m_mis);
      chk("op_count",  opc,           m_cnt % 256);
      chk("busy2",     busy2,         m_busy);
      chk("xor_clk2",  xclk2,         m_busy && !m_valid && (m_age == SCYC));
      chk("out_valid2", bus2.out_valid, m_valid);
      chk("out_data2", bus2.out_data, m_data2);
      chk("mismatch2", mis2,          1'b0);
      chk("in_ready2", bus2.in_ready, !m_busy);
      chk("xor_ab2",   {xa2, xb2},    {m_xa, m_xb});
      chk("op_count2", opc2,          m_cnt % 4);
    end
  end

  // Operand stability around every xor_clk pulse.
  property p_setup;
    @(posedge clk) disable iff (rst) $rose(xclk) |-> ($past({xa, xb}, SCYC) == {xa, xb});
  endproperty
  property p_hold;
    @(posedge clk) disable iff (rst) $rose(xclk) |-> ##HCYC ($past({xa, xb}, HCYC) == {xa, xb});
  endproperty
  a_setup: assert property (p_setup) else begin
    n_total++;
    $display("FAIL sva_setup: operands moved inside the setup window");
  end
  a_hold: assert property (p_hold) else begin
    n_total++;
    $display("FAIL sva_hold: operands moved inside the hold window");
  end

  // ---------------- stimulus helpers (called at a falling edge)
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 20, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("result_timeout", n < 20, 1'b1);
    @(negedge clk);
  endtask

  logic [W-1:0] pa [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] pb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [W-1:0] got [$];

  initial begin
    int idx, c, n;
    rst = 1'b1; stuck = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_op_count", opc, 8'd0);
    chk("rst_xor_clk", xclk, 1'b0);

    // 1: single op 1,0 with literal timing
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1_busy", busy, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("t1_xor_clk", xclk, (e == 2));
      chk("t1_out_valid", bus.out_valid, (e == 4));
    end
    chk("t1_out_data", bus.out_data, 1'b1);
    chk("t1_mismatch", mis, 1'b0);
    chk("t1_count_pre", opc, 8'd0);
    @(negedge clk);
    chk("t1_count", opc, 8'd1);
    chk("t1_idle", bus.in_ready, 1'b1);

    // 2: four pairs streamed with in_valid held
    do_reset();
    bus.out_ready = 1'b1;
    idx = 0; c = 0;
    got.delete();
    while (got.size() < 4 && c < 80) begin
      @(negedge clk);
      c++;
      if (bus.out_valid) got.push_back(bus.out_data);
      if (idx < 4) begin
        bus.in_valid = 1'b1; bus.in_a = pa[idx]; bus.in_b = pb[idx];
        if (bus.in_ready) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("t2_results", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("t2_result", got[i], exp_seq[i]);
    @(negedge clk);
    chk("t2_count", opc, 8'd4);

    // 3: stalled consumer
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1;
    @(negedge clk);
    bus.in_a = 1'b0; bus.in_b = 1'b1;   // offered while busy, must be ignored
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("t3_timeout", n < 20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_held", bus.out_valid, 1'b1);
      chk("t3_data_held", bus.out_data, 1'b0);
      chk("t3_xor_ab", {xa, xb}, 2'b11);
      chk("t3_in_ready", bus.in_ready, 1'b0);
      if (i < 4) @(negedge clk);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_release_idle", busy, 1'b0);
    chk("t3_release_count", opc, 8'd1);

    // 4: stuck-at-0 cell sets sticky mismatch
    do_reset();
    stuck = 1'b1;
    run_op(1'b1, 1'b0);
    chk("t4_stuck_data", bus.out_data, 1'b0);
    chk("t4_mismatch", mis, 1'b1);
    stuck = 1'b0;
    run_op(1'b0, 1'b1);
    chk("t4_good_data", bus.out_data, 1'b1);
    chk("t4_sticky", mis, 1'b1);
    do_reset();
    chk("t4_cleared", mis, 1'b0);

    // 5: reset during SETUP, then during STROBE, then a fresh op
    run_op(1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5a_xor_clk", xclk, 1'b0);
    chk("t5a_busy", busy, 1'b0);
    chk("t5a_out_valid", bus.out_valid, 1'b0);
    chk("t5a_count", opc, 8'd0);
    bus.in_valid = 1'b1; bus.in_a = 1'b0; bus.in_b = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5b_strobe", xclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5b_xor_clk", xclk, 1'b0);
    chk("t5b_busy", busy, 1'b0);
    chk("t5b_out_valid", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("t5c_out_valid", bus.out_valid, (e == 4));
    end
    chk("t5c_out_data", bus.out_data, 1'b1);
    @(negedge clk);

    // 6: five ops, 2-bit counter wraps to 1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] iv;
      iv = i;
      run_op(iv[0], 1'b1);
    end
    chk("t6_count2", opc2, 2'd1);
    chk("t6_count8", opc, 8'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
